// File: rtl/mcmem_arb_pkg.sv
// Shared definitions for the mcmem two-port arbiter.
// Contents:
//    state_t   access FSM state encoding (IDLE, BUSY, DONE), 2 bits
//    PORT_CPU  port index of the multicycle CPU (port 0)
//    PORT_AUX  port index of the DMA / program loader (port 1)
package mcmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: combinational winner selection plus the register
// remembering which port was granted last.
// Build option: MCMEM_ARB_FIXED_PRIO_EN
//    defined   - fixed priority, port 0 always wins a tie, no history kept
//    undefined - round robin, a tie goes to the port not granted last time
// Ports:
//    clk     in   system clock
//    clrn    in   asynchronous active-low reset
//    req0    in   request from port 0
//    req1    in   request from port 1
//    update  in   strobe: the current winner is being granted this cycle
//    winner  out  selected port index (only meaningful when a request is up)
module rr_arb2
    import mcmem_arb_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic winner
);

`ifdef MCMEM_ARB_FIXED_PRIO_EN

    logic unused_history;
    assign unused_history = &{1'b0, clk, clrn, update};

    assign winner = req0 ? PORT_CPU : PORT_AUX;

`else

    logic last_gnt;

    // Reset to port 1 so that port 0 wins the very first tie.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_gnt <= PORT_AUX;
        end else if (update) begin
            last_gnt <= winner;
        end
    end

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = PORT_AUX;
        end
    end

`endif

endmodule

// File: rtl/mcmem_arbiter.sv
// Shares the single multicycle-computer memory between the CPU (port 0) and
// a second master (port 1). A granted request is registered, driven onto the
// memory for MEM_LAT cycles, and completed with a one-cycle ack. Every access
// takes MEM_LAT+2 cycles from request to ack, and a dead IDLE cycle always
// separates two grants.
// Build option: MCMEM_ARB_FIXED_PRIO_EN (see rr_arb2) selects fixed priority
// instead of round robin; timing is identical in both builds.
// Parameters: AW address width, DW data width, MEM_LAT memory latency (>=1).
// Ports:
//    clk, clrn                      clock, asynchronous active-low reset
//    p0_req/we/adr/wdata            port 0 request (held until p0_ack)
//    p0_ack, p0_rdata               port 0 completion pulse and read data
//    p1_*                           same for port 1
//    mem_adr, mem_tom, mem_wmem     memory address, write data, write enable
//    mem_fromm                      memory read data
//    busy                           an access is in progress
//    gnt_id                         port owning the current / last access
module mcmem_arbiter
    import mcmem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_tom,
    output logic          mem_wmem,
    input  logic [DW-1:0] mem_fromm,
    output logic          busy,
    output logic          gnt_id
);

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] lat_cnt;
    logic          lat_we;
    logic [AW-1:0] lat_adr;
    logic [DW-1:0] lat_wdata;
    logic          winner;
    logic          grant;
    logic          last_busy;

    assign grant     = (state == IDLE) && (p0_req || p1_req);
    assign last_busy = (state == BUSY) && (lat_cnt == LAT_LAST);

    // The latched request feeds the memory directly; it only changes on a
    // grant, so the memory pins keep their last values outside BUSY.
    assign mem_adr = lat_adr;
    assign mem_tom = lat_wdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .clrn   (clrn),
        .req0   (p0_req),
        .req1   (p1_req),
        .update (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_wmem   = 1'b0;
        p0_ack     = 1'b0;
        p1_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy     = 1'b1;
                mem_wmem = lat_we;
                if (last_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                p0_ack     = (gnt_id == PORT_CPU);
                p1_ack     = (gnt_id == PORT_AUX);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lat_cnt <= '0;
        end else if (state == BUSY && !last_busy) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else begin
            lat_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lat_we    <= 1'b0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            gnt_id    <= PORT_CPU;
        end else if (grant) begin
            lat_we    <= (winner == PORT_AUX) ? p1_we    : p0_we;
            lat_adr   <= (winner == PORT_AUX) ? p1_adr   : p0_adr;
            lat_wdata <= (winner == PORT_AUX) ? p1_wdata : p0_wdata;
            gnt_id    <= winner;
        end
    end

    // Read data is captured on the final BUSY cycle; writes leave both
    // ports' rdata untouched.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (last_busy && !lat_we) begin
            if (gnt_id == PORT_AUX) begin
                p1_rdata <= mem_fromm;
            end else begin
                p0_rdata <= mem_fromm;
            end
        end
    end

endmodule

// File: tb/tb_mcmem_arbiter.sv
// Testbench for mcmem_arbiter. Directed checks of reset, single reads and
// writes, tie arbitration and reset abort (on a MEM_LAT=3 instance), then a
// randomized phase where each port issues its own traffic and a scoreboard
// compares every ack against the expected response pushed at issue time.
// Build option MCMEM_ARB_FIXED_PRIO_EN selects the fixed-priority checks.
module tb_mcmem_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [31:0] p0_adr, p0_wdata, p0_rdata, p1_adr, p1_wdata, p1_rdata;
    logic [31:0] mem_adr, mem_tom, mem_fromm;
    logic        mem_wmem, busy, gnt_id;

    logic        clrn_b;
    logic        b_p1_req, b_p1_we, b_p0_ack, b_p1_ack;
    logic [31:0] b_p1_adr, b_p1_wdata, b_p0_rdata, b_p1_rdata;
    logic [31:0] b_mem_adr, b_mem_tom;
    logic        b_mem_wmem, b_busy, b_gnt_id;

    always #5 clk = ~clk;

    mcmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
        .clk(clk), .clrn(clrn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_adr(mem_adr), .mem_tom(mem_tom), .mem_wmem(mem_wmem),
        .mem_fromm(mem_fromm), .busy(busy), .gnt_id(gnt_id)
    );

    mcmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_lat3 (
        .clk(clk), .clrn(clrn_b),
        .p0_req(1'b0), .p0_we(1'b0), .p0_adr(32'h0), .p0_wdata(32'h0),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_adr(b_p1_adr), .p1_wdata(b_p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .mem_adr(b_mem_adr), .mem_tom(b_mem_tom), .mem_wmem(b_mem_wmem),
        .mem_fromm(32'h0), .busy(b_busy), .gnt_id(b_gnt_id)
    );

    // Word-addressed memory model with asynchronous read.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    assign mem_fromm = mem[mem_adr[9:2]];

    always @(posedge clk) begin
        if (mem_wmem) mem[mem_adr[9:2]] <= mem_tom;
    end

    typedef struct {
        logic        we;
        logic        chk;
        logic [31:0] rd;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model_rd[2];
    logic        model_rd_ok[2];
    logic [31:0] held[2];
    logic        held_ok[2];
    bit          sb_en = 1'b0;
    logic        last_served;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: got unexpected event, required none", name);
    endtask

    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [31:0] adr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_adr = adr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_adr = adr; p0_wdata = wdata;
        end
    endtask

    // One directed access on the MEM_LAT=1 instance; lat counts cycles from
    // the request cycle to the ack cycle inclusive (0 if it never came).
    task automatic apply_stimulus(input logic port, input logic we, input logic [31:0] adr,
                                  input logic [31:0] wdata, output int lat, output int wcnt,
                                  output logic [31:0] rd);
        @(posedge clk); #1;
        set_port(port, 1'b1, we, adr, wdata);
        lat = 0; wcnt = 0; rd = 32'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_wmem) wcnt++;
            if (port ? p1_ack : p0_ack) begin
                lat = n + 1;
                rd = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
        last_served = port;
    endtask

    task automatic score(input logic port);
        exp_t        e;
        logic [31:0] rd_now;
        logic [31:0] other_now;
        rd_now    = port ? p1_rdata : p0_rdata;
        other_now = port ? p0_rdata : p1_rdata;
        if ((port ? q1.size() : q0.size()) == 0) begin
            fail_now(port ? "p1 spurious ack" : "p0 spurious ack");
            return;
        end
        e = port ? q1.pop_front() : q0.pop_front();
        if (!e.we || e.chk) check_output(port ? "p1_rdata" : "p0_rdata", rd_now, e.rd);
        if (held_ok[!port]) check_output("other port rdata hold", other_now, held[!port]);
        if (!e.we) begin
            held[port]    = e.rd;
            held_ok[port] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            if (p0_ack && p1_ack) fail_now("both acks at once");
            if (p0_ack) score(1'b0);
            if (p1_ack) score(1'b1);
        end
    end

    // Each port works in its own address region so its expected read data
    // depends only on its own earlier writes.
    task automatic run_random(input logic port, input int count);
        exp_t        e;
        int          word;
        logic        we;
        logic [31:0] wdata;
        bit          got;
        for (int t = 0; t < count; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            we    = 1'($urandom_range(0, 1));
            word  = (port ? 128 : 64) + int'($urandom_range(0, 63));
            wdata = $urandom;
            if (we) begin
                ref_mem[word] = wdata;
                e.we = 1'b1; e.chk = model_rd_ok[port]; e.rd = model_rd[port];
            end else begin
                model_rd[port]    = ref_mem[word];
                model_rd_ok[port] = 1'b1;
                e.we = 1'b0; e.chk = 1'b1; e.rd = ref_mem[word];
            end
            if (port) q1.push_back(e); else q0.push_back(e);
            set_port(port, 1'b1, we, 32'(word) << 2, wdata);
            got = 1'b0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (port ? p1_ack : p0_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) fail_now(port ? "p1 ack timeout" : "p0 ack timeout");
            @(posedge clk); #1;
            set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, wcnt, acks, cyc, prev;
        logic [31:0] rd;
        logic        exp_port;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem[4] = 32'hDEADBEEF;
        model_rd_ok[0] = 1'b0; model_rd_ok[1] = 1'b0;
        held_ok[0] = 1'b0; held_ok[1] = 1'b0;
        model_rd[0] = 32'h0; model_rd[1] = 32'h0;
        held[0] = 32'h0; held[1] = 32'h0;
        last_served = 1'b1;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_adr = 32'h0; b_p1_wdata = 32'h0;
        clrn_b = 1'b0;

        // Reset with both requests raised.
        clrn = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_output("reset busy", 32'(busy), 32'h0);
        check_output("reset acks", {30'h0, p1_ack, p0_ack}, 32'h0);
        check_output("reset mem_wmem", 32'(mem_wmem), 32'h0);
        check_output("reset mem_adr", mem_adr, 32'h0);
        check_output("reset mem_tom", mem_tom, 32'h0);
        check_output("reset gnt_id", 32'(gnt_id), 32'h0);
        check_output("reset rdata", p0_rdata | p1_rdata, 32'h0);

        @(posedge clk); #1;
        clrn = 1'b1;
        clrn_b = 1'b1;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                lat = n + 1;
                check_output("first grant goes to p0", {30'h0, p1_ack, p0_ack}, 32'h1);
                check_output("first read data", p0_rdata, init_val(0));
                break;
            end
        end
        check_output("first access latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_served = 1'b0;

        // Single read, write from port 1, read back from port 0.
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, wcnt, rd);
        check_output("p0 read latency", 32'(lat), 32'd3);
        check_output("p0 read wmem cycles", 32'(wcnt), 32'd0);
        check_output("p0 read data", rd, 32'hDEADBEEF);

        apply_stimulus(1'b1, 1'b1, 32'h20, 32'h12345678, lat, wcnt, rd);
        check_output("p1 write latency", 32'(lat), 32'd3);
        check_output("p1 write wmem cycles", 32'(wcnt), 32'd1);
        check_output("p1 rdata unchanged by write", rd, 32'h0);

        apply_stimulus(1'b0, 1'b0, 32'h20, 32'h0, lat, wcnt, rd);
        check_output("p0 readback latency", 32'(lat), 32'd3);
        check_output("p0 readback data", rd, 32'h12345678);

        // Both ports hold their requests continuously.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
`ifdef MCMEM_ARB_FIXED_PRIO_EN
        exp_port = 1'b0;
`else
        exp_port = ~last_served;
`endif
        acks = 0; prev = 0;
        for (int n = 0; n < 60 && acks < 8; n++) begin
            @(negedge clk);
            cyc = n + 1;
            if (p0_ack || p1_ack) begin
                check_output("tie winner", 32'(p1_ack), 32'(exp_port));
                check_output("tie ack spacing", 32'(cyc - prev), 32'd3);
                prev = cyc;
                acks++;
`ifndef MCMEM_ARB_FIXED_PRIO_EN
                exp_port = ~exp_port;
`endif
            end
        end
        check_output("tie ack count", 32'(acks), 32'd8);
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef MCMEM_ARB_FIXED_PRIO_EN
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (p1_ack) begin
                lat = n + 1;
                break;
            end
        end
        check_output("p1 served after p0 drops", 32'(lat), 32'd3);
        @(posedge clk); #1;
`endif
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // MEM_LAT=3: complete write, then reset during the second BUSY cycle.
        @(posedge clk); #1;
        b_p1_req = 1'b1; b_p1_we = 1'b1; b_p1_adr = 32'h40; b_p1_wdata = 32'hCAFEF00D;
        lat = 0; wcnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_mem_wmem) wcnt++;
            if (b_p1_ack) begin
                lat = n + 1;
                break;
            end
        end
        check_output("lat3 write latency", 32'(lat), 32'd5);
        check_output("lat3 wmem cycles", 32'(wcnt), 32'd3);
        @(posedge clk); #1;
        b_p1_req = 1'b0;

        @(posedge clk); #1;
        b_p1_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("lat3 first busy cycle", {30'h0, b_busy, b_mem_wmem}, 32'h3);
        @(posedge clk); #2;
        clrn_b = 1'b0;
        #1;
        check_output("abort mem_wmem", 32'(b_mem_wmem), 32'h0);
        check_output("abort busy", 32'(b_busy), 32'h0);
        check_output("abort mem_adr", b_mem_adr, 32'h0);
        b_p1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn_b = 1'b1;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (b_p1_ack || b_busy) acks++;
        end
        check_output("no ack or activity after abort", 32'(acks), 32'd0);

        // Randomized traffic from both ports against the scoreboard.
        sb_en = 1'b1;
        fork
            run_random(1'b0, 40);
            run_random(1'b1, 40);
        join
        repeat (4) @(negedge clk);
        check_output("p0 scoreboard drained", 32'(q0.size()), 32'd0);
        check_output("p1 scoreboard drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
